// File: rtl/imem_if.sv
// Instruction-fetch request/response bus between a fetch stage (master)
// and an instruction memory (slave).
interface imem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_resp.sv
// Instruction-memory responder: one outstanding word fetch, fixed wait states,
// valid/ready response, flush abort and a preload write port.
module imem_resp #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  imem_if.slave       bus,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        busy
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg;
  logic        err_reg;
  logic [31:0] rsp_instr_reg;
  logic [31:0] rsp_addr_reg;
  logic        rsp_err_reg;

  logic        accept;
  logic        read_edge;
  logic        ready_int;
  logic [31:0] rd_addr;
  logic        rd_err;

  logic [31:0] mem [DEPTH];

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    read_edge  = 1'b0;
    ready_int  = 1'b0;
    rd_addr    = addr_reg;
    rd_err     = err_reg;
    case (state_reg)
      IDLE: begin
        ready_int = rst & ~bus.flush;
        if (bus.req_valid && ready_int) begin
          accept  = 1'b1;
          rd_addr = bus.req_addr;
          rd_err  = addr_bad(bus.req_addr);
          // Zero wait states: the accept edge is also the read edge.
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            read_edge  = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == 4'd1) begin
          state_next = RESP;
          read_edge  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (bus.flush || bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      err_reg       <= 1'b0;
      rsp_instr_reg <= RESET_INSTR;
      rsp_addr_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg <= bus.req_addr;
        err_reg  <= addr_bad(bus.req_addr);
      end
      // Response fields only change here, so they hold through stalls and after the handshake.
      if (read_edge) begin
        rsp_instr_reg <= rd_err ? RESET_INSTR : mem[rd_addr[AW+1:2]];
        rsp_addr_reg  <= rd_addr;
        rsp_err_reg   <= rd_err;
      end
    end
  end

  // Read-before-write: a load landing on the read edge leaves the old word in the response.
  always_ff @(posedge clk) begin
    if (ld_en && !addr_bad(ld_addr)) mem[ld_addr[AW+1:2]] <= ld_data;
  end

  assign bus.req_ready = ready_int;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_instr = rsp_instr_reg;
  assign bus.rsp_addr  = rsp_addr_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_imem_resp.sv
// Self-checking bench for imem_resp: a WAIT_CYCLES=2/DEPTH=256 instance and a
// WAIT_CYCLES=0/DEPTH=16 instance, checked against a word-array reference model.
module tb_imem_resp;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int W0 = 2;
  localparam int D0 = 256;
  localparam int D1 = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        busy0, busy1;

  imem_if b0 ();
  imem_if b1 ();

  imem_resp #(.DEPTH(D0), .WAIT_CYCLES(W0), .RESET_INSTR(NOP)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .busy(busy0));

  imem_resp #(.DEPTH(D1), .WAIT_CYCLES(0), .RESET_INSTR(NOP)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .busy(busy1));

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  logic [31:0] model [D0];

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic bad(input logic [31:0] a, input int depth);
    return (a % 4 != 0) || ((a / 4) >= 32'(depth));
  endfunction

  function automatic logic [31:0] expect_word(input logic [31:0] a, input int depth);
    return bad(a, depth) ? NOP : model[a / 4];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    if (!bad(a, D0)) model[a / 4] = d;
  endtask

  // Full fetch on dut0 with 'stall' cycles of rsp_ready=0 once the response is up.
  task automatic fetch(input logic [31:0] a, input int stall);
    logic [31:0] ei;
    logic        ee;
    int          cyc;
    ei = expect_word(a, D0);
    ee = bad(a, D0);
    b0.req_valid = 1'b1; b0.req_addr = a; b0.rsp_ready = 1'b0;
    chk("req_ready_idle", 32'(b0.req_ready), 32'd1);
    @(negedge clk);
    b0.req_valid = 1'b0; b0.req_addr = $urandom;
    cyc = 1;
    while (!b0.rsp_valid && cyc < 20) begin
      chk("busy_wait", 32'(busy0), 32'd1);
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(W0 + 1));
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk("stall_valid", 32'(b0.rsp_valid), 32'd1);
      end
      chk("rsp_instr", b0.rsp_instr, ei);
      chk("rsp_addr", b0.rsp_addr, a);
      chk("rsp_err", 32'(b0.rsp_err), 32'(ee));
      chk("req_ready_resp", 32'(b0.req_ready), 32'd0);
    end
    b0.rsp_ready = 1'b1;
    @(negedge clk);
    b0.rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(b0.rsp_valid), 32'd0);
    chk("post_hs_busy", 32'(busy0), 32'd0);
    chk("post_hs_hold", b0.rsp_instr, ei);
    $display("[TB] fetch addr=%h stall=%0d instr=%h err=%0d", a, stall, b0.rsp_instr, b0.rsp_err);
  endtask

  // Single fetch on dut1 (no wait states) with rsp_ready held high.
  task automatic fetch1(input logic [31:0] a);
    b1.req_valid = 1'b1; b1.req_addr = a; b1.rsp_ready = 1'b1;
    @(negedge clk);
    b1.req_valid = 1'b0;
    chk("w0_valid", 32'(b1.rsp_valid), 32'd1);
    chk("w0_instr", b1.rsp_instr, expect_word(a, D1));
    chk("w0_err", 32'(b1.rsp_err), 32'(bad(a, D1)));
    chk("w0_addr", b1.rsp_addr, a);
    @(negedge clk);
    b1.rsp_ready = 1'b0;
    chk("w0_done", 32'(b1.rsp_valid), 32'd0);
    $display("[TB] fetch0 addr=%h instr=%h err=%0d", a, b1.rsp_instr, b1.rsp_err);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return 32'($urandom_range(0, D0 - 1)) * 4;
    if (r == 7) return 32'($urandom_range(0, D0 * 4 - 1)) | 32'd1;
    return 32'($urandom_range(D0, 4095)) * 4;
  endfunction

  initial begin
    logic [31:0] old_w, new_w;
    int          hold;
    b0.req_valid = 0; b0.req_addr = 0; b0.flush = 0; b0.rsp_ready = 0;
    b1.req_valid = 0; b1.req_addr = 0; b1.flush = 0; b1.rsp_ready = 0;

    // Reset and idle
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(b0.req_ready), 32'd0);
    chk("rst_valid", 32'(b0.rsp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(b0.req_ready), 32'd1);
    chk("idle_valid", 32'(b0.rsp_valid), 32'd0);
    chk("idle_instr", b0.rsp_instr, NOP);
    chk("idle_addr", b0.rsp_addr, 32'd0);
    chk("idle_err", 32'(b0.rsp_err), 32'd0);
    chk("idle_busy", 32'(busy0), 32'd0);
    $display("[TB] reset released");

    for (int i = 0; i < D0; i++) preload(32'(i) * 4, $urandom);
    preload(32'h10, 32'h00A00093);

    // Basic, backpressure, error cases
    fetch(32'h10, 0);
    fetch(32'h10, 5);
    fetch(32'h12, 0);
    fetch(32'h400, 1);

    // Out-of-range and misaligned loads must not alias into memory
    preload(32'h400, 32'hDEADBEEF);
    preload(32'h1, 32'hCAFEF00D);
    fetch(32'h0, 0);

    // Flush during WAIT
    b0.req_valid = 1'b1; b0.req_addr = 32'h20;
    @(negedge clk);
    b0.req_valid = 1'b0;
    b0.flush = 1'b1;
    @(negedge clk);
    b0.flush = 1'b0;
    chk("flush_wait_busy", 32'(busy0), 32'd0);
    hold = 0;
    for (int i = 0; i < 5; i++) begin
      if (b0.rsp_valid) hold++;
      @(negedge clk);
    end
    chk("flush_wait_no_rsp", 32'(hold), 32'd0);
    $display("[TB] flush in WAIT");

    // Flush while RESP is stalled
    b0.req_valid = 1'b1; b0.req_addr = 32'h24;
    @(negedge clk);
    b0.req_valid = 1'b0;
    repeat (W0 + 1) @(negedge clk);
    chk("flush_resp_up", 32'(b0.rsp_valid), 32'd1);
    b0.flush = 1'b1;
    @(negedge clk);
    b0.flush = 1'b0;
    chk("flush_resp_drop", 32'(b0.rsp_valid), 32'd0);
    chk("flush_resp_busy", 32'(busy0), 32'd0);
    $display("[TB] flush in RESP");

    // Flush together with req_valid in IDLE
    b0.req_valid = 1'b1; b0.flush = 1'b1; b0.req_addr = 32'h28;
    #1;
    chk("flush_idle_ready", 32'(b0.req_ready), 32'd0);
    @(negedge clk);
    b0.req_valid = 1'b0; b0.flush = 1'b0;
    chk("flush_idle_not_acc", 32'(busy0), 32'd0);
    $display("[TB] flush in IDLE");

    // Reset mid-WAIT
    b0.req_valid = 1'b1; b0.req_addr = 32'h2C;
    @(negedge clk);
    b0.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(b0.req_ready), 32'd0);
    rst = 1'b1;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_instr", b0.rsp_instr, NOP);
    chk("midrst_addr", b0.rsp_addr, 32'd0);
    hold = 0;
    for (int i = 0; i < 6; i++) begin
      if (b0.rsp_valid) hold++;
      @(negedge clk);
    end
    chk("midrst_no_rsp", 32'(hold), 32'd0);
    $display("[TB] reset during WAIT");

    // Preload racing the read edge
    old_w = model[32'h30 / 4];
    new_w = ~old_w ^ 32'h5A5A0001;
    b0.req_valid = 1'b1; b0.req_addr = 32'h30;
    @(negedge clk);
    b0.req_valid = 1'b0;
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 32'h30; ld_data = new_w;
    @(negedge clk);
    ld_en = 1'b0;
    model[32'h30 / 4] = new_w;
    chk("race_valid", 32'(b0.rsp_valid), 32'd1);
    chk("race_old", b0.rsp_instr, old_w);
    b0.rsp_ready = 1'b1;
    @(negedge clk);
    b0.rsp_ready = 1'b0;
    $display("[TB] race returned %h", b0.rsp_instr);
    fetch(32'h30, 0);

    // Zero wait states
    fetch1(32'hC);
    fetch1(32'h3C);
    fetch1(32'h40);
    fetch1(32'h6);

    // Randomised mix of loads and fetches
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) preload(rand_addr(), $urandom);
      else fetch(rand_addr(), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 8; i++) fetch1(32'($urandom_range(0, 2 * D1 * 4 - 1)));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/imem_resp.md
Name: imem_resp

Overview:
- Instruction-memory responder: the memory end of the instruction-fetch interface; inst_f is the requester.
- Accepts one word-aligned fetch request at a time.
- Models a configurable number of wait states.
- Returns the instruction with a valid/ready handshake.
- Includes a preload write port (bench/boot loader) and a flush input so a redirecting fetch stage can abort an in-flight access.

Parameters:
- DEPTH, 256, number of 32-bit instruction words.
- WAIT_CYCLES, 2, wait states between request accept and response; legal 0..15.
- RESET_INSTR, 32'h00000013, NOP returned on error and driven on rsp_instr out of reset.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low (0 = reset)
- req_valid  input  1  fetch request present
- req_ready  output  1  responder can accept a request this cycle
- req_addr  input  32  byte address of requested instruction
- flush  input  1  abort any in-flight request (branch/jump redirect)
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester consumes the response
- rsp_instr  output  32  fetched instruction word
- rsp_addr  output  32  byte address belonging to rsp_instr
- rsp_err  output  1  request was misaligned or out of range
- ld_en  input  1  preload write strobe
- ld_addr  input  32  preload byte address
- ld_data  input  32  preload data word
- busy  output  1  state is not IDLE

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE and the wait counter clears.
  - Outputs: rsp_valid=0, rsp_err=0, rsp_addr=0, rsp_instr=RESET_INSTR, busy=0.
  - req_ready=0 while rst==0.
  - Memory contents are not cleared.
  - Reset mid-WAIT or mid-RESP drops the request; no response is ever issued for it.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = ~flush.
  - Accept when req_valid & req_ready: latch req_addr and compute the error flag.
  - WAIT_CYCLES==0: next state RESP. Otherwise: next state WAIT, counter loaded with WAIT_CYCLES.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle. When counter==1, next state is RESP.
  - flush=1 returns to IDLE next cycle; the counter is discarded.
- Transition into RESP (the read edge):
  - rsp_instr <= mem[addr[31:2]], or RESET_INSTR if the error flag is set.
  - rsp_addr <= latched address.
  - rsp_err <= error flag.
  - rsp_valid <= 1.
- RESP:
  - req_ready=0.
  - rsp_instr, rsp_addr and rsp_err stay stable while rsp_valid & ~rsp_ready.
  - rsp_valid & rsp_ready: next state IDLE, rsp_valid <= 0. No back-to-back accept in the same cycle.
  - flush=1 (with or without rsp_ready): next state IDLE, rsp_valid <= 0; the response counts as discarded.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Error rule: rsp_err=1 when addr[1:0]!=0 or addr[31:2] >= DEPTH.
  - An error still completes the handshake normally; it never hangs.
- Preload:
  - ld_en=1 writes mem[ld_addr[31:2]] <= ld_data on the clock edge, in any state.
  - Ignored if ld_addr is misaligned or out of range.
  - A load to the same word on the read edge: the response returns the OLD word; a later fetch sees the new word.
- rsp_instr/rsp_addr/rsp_err hold their last values after the handshake until the next read edge.
- Simultaneous flush and req_valid in IDLE: the request is not accepted; the requester must re-present it.

Test Plan:
- Reset and idle: hold rst=0 for 2 cycles, then release -> rsp_valid=0, rsp_instr=32'h00000013, busy=0, req_ready=1 on the first cycle after release.
- Basic fetch (WAIT_CYCLES=2): preload mem[4]=32'h00A00093, request addr 32'h10 with rsp_ready=1 -> rsp_valid rises 3 cycles after accept, rsp_instr=32'h00A00093, rsp_addr=32'h10, rsp_err=0; IDLE one cycle later.
- Backpressure: as basic fetch but rsp_ready=0 for 5 cycles -> rsp_valid and all response fields stable for 5 cycles, req_ready=0; the handshake on cycle 6 returns to IDLE.
- Errors: request 32'h12 -> rsp_err=1, rsp_instr=32'h00000013. Request 32'h400 with DEPTH=256 -> rsp_err=1, no hang.
- Flush: flush during WAIT (1 cycle after accept) -> no rsp_valid pulse, IDLE next cycle. Flush while RESP is stalled -> rsp_valid drops next cycle. Flush plus req_valid in IDLE -> req_ready=0, request not accepted.
- Mid-operation reset and preload race:
  - rst=0 during WAIT -> no response ever appears.
  - ld_en to the requested word on the read edge -> old data returned; a refetch returns the new data.
  - With WAIT_CYCLES=0, the response arrives 1 cycle after accept.
